// File: rtl/alu_mc.sv
// Accumulator/B-register ALU for the bus datapath: eight operations, a registered
// C/Z/N/V flags register, and a multi-cycle unsigned shift-and-add multiplier.
module alu_mc #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] bus,
    input  logic             la,
    input  logic             lb,
    input  logic [2:0]       op,
    input  logic             wr,
    input  logic             ea,
    input  logic             eu,
    input  logic             eb,
    output logic [WIDTH-1:0] out_accumulator,
    output logic [WIDTH-1:0] out_adder,
    output logic [WIDTH-1:0] out_b,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [3:0]         r_flags;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_opb;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [3:0]         w_alu_flags;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [3:0]         w_mul_flags;
    logic               w_start;
    logic               w_finish;

    // Combinational ALU result and the flags a commit would latch
    always_comb begin
        w_res = {WIDTH{1'b0}};
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_opb = (op == OP_SUB) ? ~r_b : r_b;
        w_sum = {1'b0, r_a} + {1'b0, w_opb} + {{WIDTH{1'b0}}, (op == OP_SUB)};
        case (op)
            OP_ADD, OP_SUB: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_a[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_XOR:  w_res = r_a ^ r_b;
            OP_SHL: begin
                w_res = {r_a[WIDTH-2:0], 1'b0};
                w_c   = r_a[WIDTH-1];
            end
            OP_SHR: begin
                w_res = {1'b0, r_a[WIDTH-1:1]};
                w_c   = r_a[0];
            end
            default: w_res = {WIDTH{1'b0}};
        endcase
        w_alu_flags = {w_c, (w_res == {WIDTH{1'b0}}), w_res[WIDTH-1], w_v};
    end

    // One shift-and-add step; the high half being non-zero drives both C and V
    always_comb begin
        w_prod_nxt  = r_prod + (r_mplier[0] ? r_mcand : {2*WIDTH{1'b0}});
        w_mul_flags = {(w_prod_nxt[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}),
                       (w_prod_nxt == {2*WIDTH{1'b0}}),
                       w_prod_nxt[WIDTH-1],
                       (w_prod_nxt[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}})};
    end

    // Multiply FSM next-state; loads take priority over a multiply start
    always_comb begin
        w_start     = (r_state == ST_IDLE) && !la && !lb && wr && (op == OP_MUL);
        w_finish    = (r_state == ST_RUN) && (r_cnt == CNT_ONE);
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_state_nxt = w_finish ? ST_IDLE : ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: A/B loads, commits and multiply shadow state
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_flags  <= 4'b0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mcand  <= {2*WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_prod   <= {2*WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (la) begin
                        r_a <= bus;
                    end else if (lb) begin
                        r_b <= bus;
                    end else if (wr && (op != OP_MUL)) begin
                        r_a     <= w_res;
                        r_flags <= w_alu_flags;
                    end else if (w_start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, r_a};
                        r_mplier <= r_b;
                        r_prod   <= {2*WIDTH{1'b0}};
                        r_cnt    <= CNT_INIT;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_prod   <= w_prod_nxt;
                    r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt - CNT_ONE;
                    if (w_finish) begin
                        r_a     <= w_prod_nxt[WIDTH-1:0];
                        r_b     <= w_prod_nxt[2*WIDTH-1:WIDTH];
                        r_flags <= w_mul_flags;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign out_accumulator = ea ? r_a   : {WIDTH{1'bz}};
    assign out_adder       = eu ? w_res : {WIDTH{1'bz}};
    assign out_b           = eb ? r_b   : {WIDTH{1'bz}};
    assign flags           = r_flags;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: the driver pushes expected A/B/flags from an
// arithmetic reference model, and a monitor pops and compares on strobe or done.
module tb_alu_mc;
    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         clear;
    logic [W-1:0] bus;
    logic         la, lb, wr, ea, eu, eb;
    logic [2:0]   op;
    wire  [W-1:0] o_acc, o_add, o_b;
    wire  [3:0]   flags;
    wire          busy, done;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .clear(clear), .bus(bus), .la(la), .lb(lb), .op(op), .wr(wr),
        .ea(ea), .eu(eu), .eb(eb), .out_accumulator(o_acc), .out_adder(o_add),
        .out_b(o_b), .flags(flags), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           tag;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   f;
        bit           chk_r;
        logic [W-1:0] r;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_checks = 0;
    int   n_errors = 0;
    int   tag_cnt  = 0;
    bit   strobe   = 1'b0;
    int   ma = 0, mb = 0;
    logic [3:0] mf = 4'b0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned/signed values
    function automatic void ref_alu(input int o, input int a, input int b,
                                    output int r, output logic [3:0] f);
        int sa, sb, s;
        bit c, v;
        c = 1'b0; v = 1'b0; r = 0;
        sa = (a >= M/2) ? a - M : a;
        sb = (b >= M/2) ? b - M : b;
        case (o)
            0: begin s = a + b;     r = s % M; c = (s >= M); v = (sa + sb > M/2 - 1) || (sa + sb < -M/2); end
            1: begin s = a - b + M; r = s % M; c = (s >= M); v = (sa - sb > M/2 - 1) || (sa - sb < -M/2); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a * 2) % M; c = (a >= M/2); end
            6: begin r = a / 2; c = (a % 2) == 1; end
            default: r = 0;
        endcase
        f = {c, (r == 0), (r >= M/2), v};
    endfunction

    task automatic push_state();
        exp_t e;
        int r;
        logic [3:0] fdummy;
        ref_alu(int'(op), ma, mb, r, fdummy);
        e.tag = tag_cnt++; e.a = ma[W-1:0]; e.b = mb[W-1:0]; e.f = mf;
        e.chk_r = 1'b1; e.r = r[W-1:0];
        q.push_back(e);
        strobe = 1'b1;
        @(negedge clk);
        #1 strobe = 1'b0;
    endtask

    task automatic load_a(input int v);
        la = 1'b1; bus = v[W-1:0];
        @(posedge clk); #1 la = 1'b0;
        ma = v % M;
        push_state();
    endtask

    task automatic load_b(input int v);
        lb = 1'b1; bus = v[W-1:0];
        @(posedge clk); #1 lb = 1'b0;
        mb = v % M;
        push_state();
    endtask

    task automatic alu(input int o);
        int r;
        logic [3:0] f;
        op = o[2:0]; wr = 1'b1;
        @(posedge clk); #1 wr = 1'b0;
        ref_alu(o, ma, mb, r, f);
        ma = r; mf = f;
        push_state();
    endtask

    task automatic do_mul(input bit poke, input bit b2b);
        int   p, pa, pb, nbusy;
        bit   got;
        exp_t e;
        p = ma * mb; pa = p % M; pb = p / M;
        e.tag = tag_cnt++; e.a = pa[W-1:0]; e.b = pb[W-1:0];
        e.f = {(p >= M), (p == 0), (pa >= M/2), (p >= M)};
        e.chk_r = 1'b0; e.r = '0;
        q.push_back(e);
        op = 3'd7; wr = 1'b1;
        @(posedge clk); #1 wr = 1'b0;
        nbusy = 0; got = 1'b0;
        for (int i = 0; i < 4*W && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) nbusy++;
                if (i == 1) chk("hold_A_busy", o_acc, ma);
                if (poke && i == 2) begin
                    la = 1'b1; lb = 1'b1; wr = 1'b1; bus = 8'hAA; op = 3'd0;
                end else begin
                    la = 1'b0; lb = 1'b0; wr = 1'b0; op = 3'd7;
                end
            end
        end
        la = 1'b0; lb = 1'b0; wr = 1'b0;
        chk("mul_done_seen", got, 1);
        chk("busy_cycles", nbusy, W);
        chk("busy_low_at_done", busy, 0);
        ma = pa; mb = pb; mf = e.f;
        if (!b2b) begin
            @(negedge clk);
            chk("done_pulse_width", done, 0);
        end
    endtask

    // Monitor: compare the oldest expectation whenever the DUT presents a result
    always @(negedge clk) begin
        if (strobe || done) begin
            if (q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_output: nothing expected, done=%0b (t=%0t)", done, $time);
            end else begin
                me = q.pop_front();
                chk("mon_A", o_acc, me.a);
                chk("mon_B", o_b, me.b);
                chk("mon_flags", flags, me.f);
                if (me.chk_r && eu) chk("mon_adder", o_add, me.r);
            end
        end
    end

    initial begin
        int dn;
        clear = 1'b1; bus = '0; la = 0; lb = 0; wr = 0; op = 3'd0;
        ea = 1'b1; eu = 1'b1; eb = 1'b1;
        @(negedge clk);
        chk("rst_A", o_acc, 0); chk("rst_B", o_b, 0); chk("rst_flags", flags, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_adder", o_add, 0);
        clear = 1'b0;

        load_a(8'h05);
        load_b(8'h03);
        la = 1'b1; lb = 1'b1; bus = 8'h22;
        @(posedge clk); #1 la = 1'b0; lb = 1'b0;
        ma = 8'h22;
        push_state();

        // asynchronous clear in the middle of a cycle
        op = 3'd0;
        @(posedge clk); #3 clear = 1'b1;
        #1;
        chk("aclr_A", o_acc, 0); chk("aclr_B", o_b, 0); chk("aclr_flags", flags, 0);
        chk("aclr_adder", o_add, 0);
        clear = 1'b0; ma = 0; mb = 0; mf = 4'b0000;

        load_a(8'h7F); load_b(8'h01); alu(0);
        chk("add_ovf_A", o_acc, 8'h80); chk("add_ovf_flags", flags, 4'b0011);
        load_a(8'hFF); alu(0);
        chk("add_wrap_A", o_acc, 8'h00); chk("add_wrap_flags", flags, 4'b1100);
        load_a(8'h03); load_b(8'h05); alu(1);
        chk("sub_neg_A", o_acc, 8'hFE); chk("sub_neg_flags", flags, 4'b0010);
        load_a(8'h05); alu(1);
        chk("sub_eq_A", o_acc, 8'h00); chk("sub_eq_flags", flags, 4'b1100);
        load_a(8'h81); alu(5);
        chk("shl_A", o_acc, 8'h02); chk("shl_flags", flags, 4'b1000);
        load_a(8'h81); alu(6);
        chk("shr_A", o_acc, 8'h40); chk("shr_flags", flags, 4'b1000);
        load_a(8'hF0); load_b(8'h3C); alu(4);
        chk("xor_A", o_acc, 8'hCC); chk("xor_flags", flags, 4'b0010);

        eu = 1'b0; #1;
        chk("adder_hiz", (o_add === {W{1'bz}}), 1);
        eu = 1'b1;
        load_a(8'h10); load_b(8'h21);
        op = 3'd0; #1 chk("adder_live_add", o_add, 8'h31);
        op = 3'd1; #1 chk("adder_live_sub", o_add, 8'hEF);
        op = 3'd7; #1 chk("adder_mul_zero", o_add, 8'h00);
        chk("adder_no_commit", o_acc, 8'h10);

        load_a(8'h0C); load_b(8'h15);
        do_mul(1'b1, 1'b0);
        chk("mul1_A", o_acc, 8'hFC); chk("mul1_B", o_b, 8'h00); chk("mul1_flags", flags, 4'b0010);
        load_a(8'hFF); load_b(8'hFF);
        do_mul(1'b0, 1'b1);
        chk("mul2_A", o_acc, 8'h01); chk("mul2_B", o_b, 8'hFE); chk("mul2_flags", flags, 4'b1001);
        do_mul(1'b0, 1'b0);
        chk("b2b_A", o_acc, 8'hFE); chk("b2b_B", o_b, 8'h00);

        // abort a multiply three cycles in
        load_a(8'h09); load_b(8'h07);
        op = 3'd7; wr = 1'b1;
        @(posedge clk); #1 wr = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        clear = 1'b1; #1;
        chk("abort_busy", busy, 0); chk("abort_A", o_acc, 0); chk("abort_B", o_b, 0);
        chk("abort_flags", flags, 0);
        clear = 1'b0; ma = 0; mb = 0; mf = 4'b0000;
        dn = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        load_a(8'h06); load_b(8'h07);
        do_mul(1'b0, 1'b0);
        chk("post_abort_A", o_acc, 8'h2A);

        for (int it = 0; it < 150; it++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k < 2)      load_a($urandom_range(0, M - 1));
            else if (k < 4) load_b($urandom_range(0, M - 1));
            else if (k < 9) alu($urandom_range(0, 6));
            else            do_mul(1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
